// File: rtl/cmp_pattern_driver.sv
// cmp_pattern_driver
//   Self-test initiator for a combinational equality comparator (x, y -> z).
//   Sweeps every operand pair of a WIDTH-bit comparator. For each pair it
//   drives x_out/y_out, waits SETTLE cycles, then samples z_in against the
//   expected (x == y). It reports pass/fail, a saturating mismatch count and
//   the first failing vector.
//
//   Optional feature macro: CMP_DRIVER_MAGNITUDE_EN
//     When defined, the inputs z_gt_in/z_lt_in are added and also checked
//     against the unsigned x > y and x < y. Any difference on z, z_gt or
//     z_lt counts as one mismatch for that vector.
//
//   Per-vector cost is SETTLE+2 cycles (DRIVE, SETTLE x WAIT, SAMPLE).
//   SETTLE must be in 1..15.
module cmp_pattern_driver #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  input  logic             z_in,
`ifdef CMP_DRIVER_MAGNITUDE_EN
  input  logic             z_gt_in,
  input  logic             z_lt_in,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] first_err_x,
  output logic [WIDTH-1:0] first_err_y
);

  localparam int            CW        = 2 * WIDTH;
  localparam logic [CW-1:0] VEC_LAST  = '1;
  localparam logic [3:0]    WAIT_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    vec_q;
  logic [3:0]       wait_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERRW-1:0]  err_q;
  logic [WIDTH-1:0] fx_q;
  logic [WIDTH-1:0] fy_q;

  logic             mismatch_d;
  logic             first_d;
  logic [ERRW-1:0]  err_d;

  // Saturating increment: the count sticks at all-ones and never wraps to 0.
  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (v == '1) ? v : v + ERRW'(1);
  endfunction

  // Mismatch detection against the held operands and the resulting next count.
  always_comb begin
    mismatch_d = (z_in != (x_q == y_q));
`ifdef CMP_DRIVER_MAGNITUDE_EN
    mismatch_d = mismatch_d
               | (z_gt_in != (x_q > y_q))
               | (z_lt_in != (x_q < y_q));
`endif
    err_d   = mismatch_d ? sat_inc(err_q) : err_q;
    // err_q can only be zero before the first mismatch because it saturates.
    first_d = mismatch_d && (err_q == '0);
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_DRIVE;
            vec_q   <= '0;
            err_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_DRIVE: begin
          x_q     <= vec_q[CW-1:WIDTH];
          y_q     <= vec_q[WIDTH-1:0];
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= S_SAMPLE;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        S_SAMPLE: begin
          err_q <= err_d;
          if (first_d) begin
            fx_q <= x_q;
            fy_q <= y_q;
          end
          if (vec_q == VEC_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            vec_q   <= vec_q + CW'(1);
            state_q <= S_DRIVE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign first_err_x = fx_q;
  assign first_err_y = fy_q;

endmodule

// File: tb/tb_cmp_pattern_driver.sv
// Testbench for cmp_pattern_driver: two instances (WIDTH=1/ERRW=8 and
// WIDTH=2/ERRW=2) each driving a behavioural comparator with selectable faults.
module tb_cmp_pattern_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start2;
  int         mode1, mode2;
  int         sel;
  int         total;
  int         bad;

  logic [0:0] x1, y1, fx1, fy1;
  logic       z1, busy1, done1, pass1;
  logic [7:0] err1;

  logic [1:0] x2, y2, fx2, fy2;
  logic       z2, busy2, done2, pass2;
  logic [1:0] err2;

  // Comparator model: 0 correct, 1 stuck at 0, 2 y tied to x, 3 inverted.
  function automatic logic model_z(input int mode, input int x, input int y);
    case (mode)
      0:       return (x == y);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return (x != y);
    endcase
  endfunction

  always_comb z1 = model_z(mode1, int'(x1), int'(y1));
  always_comb z2 = model_z(mode2, int'(x2), int'(y2));

  cmp_pattern_driver #(.WIDTH(1), .SETTLE(2), .ERRW(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .x_out(x1), .y_out(y1), .z_in(z1),
`ifdef CMP_DRIVER_MAGNITUDE_EN
    .z_gt_in(x1 > y1), .z_lt_in(x1 < y1),
`endif
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_x(fx1), .first_err_y(fy1)
  );

  cmp_pattern_driver #(.WIDTH(2), .SETTLE(2), .ERRW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .x_out(x2), .y_out(y2), .z_in(z2),
`ifdef CMP_DRIVER_MAGNITUDE_EN
    .z_gt_in(x2 > y2), .z_lt_in(x2 < y2),
`endif
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_x(fx2), .first_err_y(fy2)
  );

  // Observation mux over the selected instance.
  logic [1:0] m_x, m_y, m_fx, m_fy;
  logic       m_busy, m_done, m_pass;
  logic [7:0] m_err;
  always_comb begin
    if (sel == 0) begin
      m_x = {1'b0, x1};   m_y = {1'b0, y1};
      m_fx = {1'b0, fx1}; m_fy = {1'b0, fy1};
      m_busy = busy1; m_done = done1; m_pass = pass1; m_err = err1;
    end else begin
      m_x = x2;   m_y = y2;
      m_fx = fx2; m_fy = fy2;
      m_busy = busy2; m_done = done2; m_pass = pass2; m_err = {6'b0, err2};
    end
  end

  task automatic set_start(input logic v);
    if (sel == 0) start1 = v;
    else          start2 = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({x1, y1, busy1, done1, pass1, err1, fx1, fy1} !== '0) begin
      bad++;
      $display("FAIL reset_dut1: got x=%b y=%b busy=%b done=%b pass=%b err=%0d fx=%b fy=%b want all 0",
               x1, y1, busy1, done1, pass1, err1, fx1, fy1);
    end
    total++;
    if ({x2, y2, busy2, done2, pass2, err2, fx2, fy2} !== '0) begin
      bad++;
      $display("FAIL reset_dut2: got x=%b y=%b busy=%b done=%b pass=%b err=%0d fx=%b fy=%b want all 0",
               x2, y2, busy2, done2, pass2, err2, fx2, fy2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one full sweep on instance `which` with comparator fault `mode`.
  // Expected vectors go into a queue when start is driven and are popped as
  // the DUT presents them. With poke set, start is pulsed mid-sweep and in
  // the DONE cycle, and both must be ignored.
  task automatic run_sweep(input int which, input int mode, input bit poke, input string tag);
    int         nvec, w, emax, err, fxe, fye, xv, yv;
    logic [3:0] vq[$];
    logic [3:0] e;
    logic [3:0] fe;
    sel = which;
    if (which == 0) begin nvec = 4;  w = 1; emax = 255; mode1 = mode; end
    else            begin nvec = 16; w = 2; emax = 3;   mode2 = mode; end
    err = 0; fxe = 0; fye = 0;
    for (int v = 0; v < nvec; v++) begin
      xv = v >> w;
      yv = v & ((1 << w) - 1);
      vq.push_back(4'((xv << 2) | yv));
      if (model_z(mode, xv, yv) != (xv == yv)) begin
        if (err == 0) begin fxe = xv; fye = yv; end
        if (err < emax) err++;
      end
    end
    fe = 4'((fxe << 2) | fye);

    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    total++;
    if (m_busy !== 1'b1 || m_done !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", tag, m_busy, m_done);
    end

    for (int v = 0; v < nvec; v++) begin
      e = vq.pop_front();
      for (int r = 0; r < 3; r++) begin
        @(negedge clk);
        if (poke && v == 1 && r == 0) set_start(1'b1);
        if (poke && v == 1 && r == 1) set_start(1'b0);
        total++;
        if ({m_x, m_y} !== e || m_busy !== 1'b1 || m_done !== 1'b0) begin
          bad++;
          $display("FAIL %s vec%0d/%0d: xy=%b busy=%b done=%b want xy=%b busy=1 done=0",
                   tag, v, r, {m_x, m_y}, m_busy, m_done, e);
        end
      end
      @(negedge clk);
    end

    total++;
    if (m_done !== 1'b1 || m_busy !== 1'b1) begin
      bad++;
      $display("FAIL %s done_pulse: done=%b busy=%b want done=1 busy=1", tag, m_done, m_busy);
    end
    total++;
    if (m_pass !== (err == 0)) begin
      bad++;
      $display("FAIL %s pass: got %b want %b", tag, m_pass, (err == 0));
    end
    total++;
    if (m_err !== 8'(err)) begin
      bad++;
      $display("FAIL %s err_count: got %0d want %0d", tag, m_err, err);
    end
    total++;
    if ({m_fx, m_fy} !== fe) begin
      bad++;
      $display("FAIL %s first_err: got (%0d,%0d) want (%0d,%0d)", tag, m_fx, m_fy, fxe, fye);
    end

    if (poke) set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    total++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_err !== 8'(err) || m_pass !== (err == 0)) begin
      bad++;
      $display("FAIL %s after_done: done=%b busy=%b err=%0d pass=%b want done=0 busy=0 err=%0d pass=%b",
               tag, m_done, m_busy, m_err, m_pass, err, (err == 0));
    end
    @(negedge clk);
    total++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || {m_x, m_y} !== e || {m_fx, m_fy} !== fe) begin
      bad++;
      $display("FAIL %s idle_hold: busy=%b done=%b xy=%b first=%b want busy=0 done=0 xy=%b first=%b",
               tag, m_busy, m_done, {m_x, m_y}, {m_fx, m_fy}, e, fe);
    end
  endtask

  task automatic test_equality();       run_sweep(0, 0, 1'b0, "eq_w1");       endtask
  task automatic test_stuck_zero();     run_sweep(0, 1, 1'b0, "stuck0_w1");   endtask
  task automatic test_tied_y();         run_sweep(0, 2, 1'b0, "tied_w1");     endtask
  task automatic test_inverted_sat();   run_sweep(1, 3, 1'b0, "inv_sat_w2");  endtask
  task automatic test_equality_w2();    run_sweep(1, 0, 1'b0, "eq_w2");       endtask
  task automatic test_start_ignored();  run_sweep(0, 1, 1'b1, "start_ign");   endtask

  task automatic test_reset_mid();
    sel = 0; mode1 = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (9) @(negedge clk);
    total++;
    if (m_x !== 2'b01 || m_y !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid_vec: got (%0d,%0d) want (1,0)", m_x, m_y);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({m_x, m_y, m_busy, m_done, m_pass, m_err, m_fx, m_fy} !== '0) begin
      bad++;
      $display("FAIL rst_mid_clear: x=%0d y=%0d busy=%b done=%b pass=%b err=%0d want all 0",
               m_x, m_y, m_busy, m_done, m_pass, m_err);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (m_busy !== 1'b0 || m_done !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_idle%0d: busy=%b done=%b want 0 0", i, m_busy, m_done);
      end
    end
    run_sweep(0, 0, 1'b0, "after_rst");
  endtask

  initial begin
    total = 0; bad = 0; sel = 0;
    mode1 = 0; mode2 = 0;
    start1 = 1'b0; start2 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_equality();
    test_stuck_zero();
    test_tied_y();
    test_inverted_sat();
    test_equality_w2();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
